// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   tx_fifo_state_t    : drain FSM state encoding used by uart_tx_fifo
//   UART_TX_FIFO_DEPTH : default transmit FIFO depth
//   UART_STAT_*        : status-register field positions read by the controller
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_BUSY = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_fifo_state_t;

    localparam int UART_TX_FIFO_DEPTH = 16;

    localparam int UART_STAT_TX_LVL_LSB  = 0;
    localparam int UART_STAT_TX_LVL_W    = $clog2(UART_TX_FIFO_DEPTH) + 1;
    localparam int UART_STAT_TX_OVF_BIT  = 8;
    localparam int UART_STAT_TX_IDLE_BIT = 9;

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x 8 register array for the transmit FIFO.
//   clk_i   : system clock
//   we_i    : write enable, writes wdata_i at waddr_i on the rising edge
//   waddr_i : write pointer
//   wdata_i : byte to store
//   raddr_i : read pointer
//   rdata_o : combinational read of the entry at raddr_i
// The array is deliberately not reset; the pointers decide what is valid.
module uart_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer between the UART bus controller and the async transmitter.
// Bytes are pushed at bus speed, stored in a circular buffer and replayed to
// the transmitter one at a time with a start pulse / busy handshake.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   push_i, push_data_i    : enqueue strobe and byte
//   full_o, empty_o        : decoded from the registered level
//   level_o                : entry count
//   ovf_o, ovf_clr_i       : sticky dropped-push flag and its clear
//   idle_o                 : FIFO empty and drain FSM idle
//   tx_start_o, tx_data_o  : one-cycle launch pulse and the launched byte
//   tx_busy_i              : transmitter busy
//
// state        | meaning
// TX_IDLE      | ready to launch; pops whenever the FIFO is not empty
// TX_WAIT_BUSY | byte launched, waiting for the transmitter to go busy
// TX_WAIT_DONE | transmitter busy with the byte, waiting for it to finish
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = UART_TX_FIFO_DEPTH,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [7:0]             push_data_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   ovf_o,
    input  logic                   ovf_clr_i,
    output logic                   idle_o,
    output logic                   tx_start_o,
    output logic [7:0]             tx_data_o,
    input  logic                   tx_busy_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
    // Down-counter: loaded on launch, abandons the byte at terminal count,
    // which gives exactly BUSY_TIMEOUT cycles in TX_WAIT_BUSY.
    localparam logic [TW-1:0] TMR_LOAD = TW'(BUSY_TIMEOUT - 1);

    tx_fifo_state_t state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           ovf_q, ovf_d;
    logic           idle_q, idle_d;
    logic           tx_start_q, tx_start_d;
    logic [7:0]     tx_data_q, tx_data_d;

    logic           full, empty, pop, push_acc, push_drop;
    logic [7:0]     rd_data;

    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign pop       = (state_q == TX_IDLE) && !empty;
    // A push into a full FIFO still fits when the head leaves the same cycle.
    assign push_acc  = push_i && (!full || pop);
    assign push_drop = push_i && full && !pop;

    uart_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (push_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (push_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            TX_IDLE: begin
                if (pop) begin
                    tx_data_d  = rd_data;
                    rd_ptr_d   = rd_ptr_q + AW'(1);
                    tx_start_d = 1'b1;
                    tmr_d      = TMR_LOAD;
                    state_d    = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = TX_WAIT_DONE;
                end else if (tmr_q == '0) begin
                    state_d = TX_IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            TX_WAIT_DONE: begin
                if (!tx_busy_i) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        case ({push_acc, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (push_drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end

        idle_d = (level_d == '0) && (state_d == TX_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= TX_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            tmr_q      <= '0;
            ovf_q      <= 1'b0;
            idle_q     <= 1'b1;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            tmr_q      <= tmr_d;
            ovf_q      <= ovf_d;
            idle_q     <= idle_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign full_o     = full;
    assign empty_o    = empty;
    assign level_o    = level_q;
    assign ovf_o      = ovf_q;
    assign idle_o     = idle_q;
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int BT    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk_i       = 1'b0;
    logic          rst_ni      = 1'b1;
    logic          push_i      = 1'b0;
    logic [7:0]    push_data_i = 8'h00;
    logic          ovf_clr_i   = 1'b0;
    logic          tx_busy_i   = 1'b0;
    logic          full_o, empty_o, ovf_o, idle_o, tx_start_o;
    logic [LW-1:0] level_o;
    logic [7:0]    tx_data_o;

    uart_tx_fifo #(
        .DEPTH        (DEPTH),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push_i),
        .push_data_i (push_data_i),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .level_o     (level_o),
        .ovf_o       (ovf_o),
        .ovf_clr_i   (ovf_clr_i),
        .idle_o      (idle_o),
        .tx_start_o  (tx_start_o),
        .tx_data_o   (tx_data_o),
        .tx_busy_i   (tx_busy_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = -1;

    // Reference model: a byte queue plus the edge number at which the
    // launcher may next pop.  With a transmitter that goes busy two edges
    // after the launch edge and stays busy L cycles, the next pop edge is
    // L+3 after the previous one; with no busy at all it is BT+1.
    byte unsigned m_q[$];
    int           m_next_pop = 0;
    logic         m_ovf      = 1'b0;
    logic [7:0]   m_data     = 8'h00;
    int           busy_len   = 10;

    // Transmitter model state
    logic tx_pending = 1'b0;
    int   tx_left    = 0;
    int   tx_len_cur = 0;

    byte unsigned emitted[$];
    int           start_edges[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic cycle(input logic p, input logic [7:0] d, input logic clr);
        logic pop, acc, drop;
        push_i      = p;
        push_data_i = d;
        ovf_clr_i   = clr;
        pop  = (m_q.size() > 0) && (edge_n + 1 >= m_next_pop);
        acc  = p && ((m_q.size() < DEPTH) || pop);
        drop = p && !acc;
        @(posedge clk_i);
        edge_n++;
        if (pop) begin
            m_data     = m_q.pop_front();
            m_next_pop = edge_n + ((busy_len == 0) ? BT + 1 : busy_len + 3);
        end
        if (acc) m_q.push_back(d);
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(negedge clk_i);
        push_i    = 1'b0;
        ovf_clr_i = 1'b0;
        chk("level", level_o, m_q.size());
        chk("full", full_o, m_q.size() == DEPTH);
        chk("empty", empty_o, m_q.size() == 0);
        chk("ovf", ovf_o, m_ovf);
        chk("start", tx_start_o, pop);
        chk("txdata", tx_data_o, m_data);
        chk("idle", idle_o, (m_q.size() == 0) && (edge_n >= m_next_pop - 1));
        if (tx_start_o) begin
            emitted.push_back(tx_data_o);
            start_edges.push_back(edge_n);
        end
        if (tx_pending) begin
            tx_busy_i  = 1'b1;
            tx_left    = tx_len_cur;
            tx_pending = 1'b0;
        end else if (tx_left > 0) begin
            tx_left--;
            if (tx_left == 0) tx_busy_i = 1'b0;
        end
        if (tx_start_o && busy_len > 0) begin
            tx_pending = 1'b1;
            tx_len_cur = busy_len;
        end
    endtask

    task automatic drain(input int max_cycles);
        int k = 0;
        while (!(m_q.size() == 0 && edge_n >= m_next_pop - 1 && !tx_busy_i && !tx_pending)
               && k < max_cycles) begin
            cycle(1'b0, 8'h00, 1'b0);
            k++;
        end
        chk("drain_in_time", k < max_cycles, 1);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_level"}, level_o, 0);
        chk({tag, "_empty"}, empty_o, 1);
        chk({tag, "_full"}, full_o, 0);
        chk({tag, "_ovf"}, ovf_o, 0);
        chk({tag, "_start"}, tx_start_o, 0);
        chk({tag, "_txdata"}, tx_data_o, 0);
        chk({tag, "_idle"}, idle_o, 1);
    endtask

    typedef struct {
        logic          push;
        logic [7:0]    data;
        logic [LW-1:0] lvl;
        logic          start;
        logic [7:0]    txd;
        logic          idle;
    } vec_t;

    vec_t        tv[15];
    byte unsigned exp_list[$];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single byte, transmitter busy 10 cycles starting one cycle after
        // the start pulse.  Row k holds the outputs after edge k.
        for (int k = 0; k < 15; k++) begin
            tv[k].push  = (k == 0);
            tv[k].data  = (k == 0) ? 8'h41 : 8'h00;
            tv[k].lvl   = (k == 0) ? LW'(1) : LW'(0);
            tv[k].start = (k == 1);
            tv[k].txd   = (k == 0) ? 8'h00 : 8'h41;
            tv[k].idle  = (k >= 13);
        end

        #2 rst_ni = 1'b0;
        #1 reset_checks("reset");
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        busy_len = 10;
        for (int k = 0; k < 15; k++) begin
            cycle(tv[k].push, tv[k].data, 1'b0);
            chk("tv_level", level_o, tv[k].lvl);
            chk("tv_start", tx_start_o, tv[k].start);
            chk("tv_txdata", tx_data_o, tv[k].txd);
            chk("tv_idle", idle_o, tv[k].idle);
        end
        exp_list.push_back(8'h41);

        // 16 back-to-back pushes; the first byte leaves after one cycle.
        busy_len = 20;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            exp_list.push_back(8'(i));
        end
        chk("fill_level15", level_o, 15);
        chk("fill_not_full", full_o, 0);

        // Top up to 16 while the launcher is in WAIT_DONE, then overflow.
        cycle(1'b1, 8'h10, 1'b0);
        exp_list.push_back(8'h10);
        chk("top_full", full_o, 1);
        chk("top_level16", level_o, 16);
        cycle(1'b1, 8'hAA, 1'b0);
        chk("drop_ovf", ovf_o, 1);
        chk("drop_level16", level_o, 16);
        cycle(1'b0, 8'h00, 1'b1);
        chk("ovfclr", ovf_o, 0);

        // Push into the full FIFO on the very edge the launcher pops.
        begin
            int k = 0;
            while (edge_n + 1 < m_next_pop && k < 100) begin
                cycle(1'b0, 8'h00, 1'b0);
                k++;
            end
            chk("pop_wait_in_time", k < 100, 1);
        end
        cycle(1'b1, 8'h55, 1'b0);
        exp_list.push_back(8'h55);
        chk("fullpop_start", tx_start_o, 1);
        chk("fullpop_level16", level_o, 16);
        chk("fullpop_ovf", ovf_o, 0);
        drain(1000);
        chk("order_count", emitted.size(), exp_list.size());
        for (int i = 0; i < emitted.size() && i < exp_list.size(); i++) begin
            chk("order_byte", emitted[i], exp_list[i]);
        end

        // Transmitter never goes busy: each byte is abandoned after BT cycles.
        busy_len = 0;
        start_edges.delete();
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        cycle(1'b1, 8'h03, 1'b0);
        drain(200);
        chk("timeout_starts", start_edges.size(), 3);
        if (start_edges.size() == 3) begin
            chk("timeout_gap1", start_edges[1] - start_edges[0], BT + 1);
            chk("timeout_gap2", start_edges[2] - start_edges[1], BT + 1);
        end

        // Reset while the transmitter holds a byte and 5 more are queued.
        busy_len = 20;
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("pre_reset_level5", level_o, 5);
        chk("pre_reset_busy", tx_busy_i, 1);
        rst_ni = 1'b0;
        #1 reset_checks("midreset");
        m_q.delete();
        m_next_pop = 0;
        m_ovf      = 1'b0;
        m_data     = 8'h00;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        start_edges.delete();
        for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b0);
        chk("post_reset_no_start", start_edges.size(), 0);

        // Randomized traffic against the model, several transmitter speeds.
        for (int ph = 0; ph < 4; ph++) begin
            drain(1000);
            case (ph)
                0:       busy_len = 0;
                1:       busy_len = 1;
                2:       busy_len = 3;
                default: busy_len = 6;
            endcase
            for (int i = 0; i < 300; i++) begin
                cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0);
            end
        end
        drain(1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Transmit buffer between the UART Wishbone controller and the async transmitter.
- Accepts byte pushes at full bus speed and stores up to DEPTH bytes.
- Replays them to the transmitter one byte at a time, with a start pulse and busy handshake.
- Lets software queue strings without polling TX-ready per character; exposes level and sticky overflow for the status register.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >=2
- BUSY_TIMEOUT, 4, cycles to wait for tx_busy_i to rise after a start pulse before abandoning the byte

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- push_i  input  1  write strobe; one byte per cycle
- push_data_i  input  8  byte to enqueue
- full_o  output  1  FIFO holds DEPTH entries
- empty_o  output  1  FIFO holds 0 entries
- level_o  output  $clog2(DEPTH)+1  current entry count
- ovf_o  output  1  sticky: a push was dropped
- ovf_clr_i  input  1  clears ovf_o
- idle_o  output  1  FIFO empty and FSM in IDLE (drain complete)
- tx_start_o  output  1  one-cycle start pulse to transmitter
- tx_data_o  output  8  byte presented with tx_start_o; held until next launch
- tx_busy_i  input  1  transmitter busy

Behaviour:
- Clocking and reset
  - Single clock domain; asynchronous, active-low reset.
  - rst_ni low: pointers=0, level_o=0, empty_o=1, full_o=0, ovf_o=0, tx_start_o=0, tx_data_o=0, idle_o=1, state=IDLE.
  - The memory array is not reset.
  - Reset mid-transmission discards all queued bytes. A byte already inside the transmitter finishes on its own; this block does not track it.
- Storage
  - Circular buffer with rd/wr pointers of $clog2(DEPTH) bits; wrap from DEPTH-1 to 0.
  - level_o is a registered counter; full_o and empty_o are decoded from level_o.
- Push rules
  - push_i with !full_o: write the byte, wr_ptr++, level+1.
  - push_i with full_o and a pop in the same cycle: accept. Level stays DEPTH.
  - push_i with full_o and no pop: drop the byte, set ovf_o next cycle.
  - Simultaneous push and pop when not full: level unchanged, both pointers advance.
  - ovf_clr_i clears ovf_o. If ovf_clr_i coincides with a dropped push, the set wins.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE, !empty: pop. tx_data_o<=mem[rd_ptr], rd_ptr++, level-1, tx_start_o<=1 for exactly one cycle; go to WAIT_BUSY with the timeout counter cleared.
  - IDLE, empty: stay.
  - WAIT_BUSY, tx_busy_i=1: go to WAIT_DONE.
  - WAIT_BUSY, otherwise: counter++. When the counter reaches BUSY_TIMEOUT, go to IDLE; the byte is lost and no flag is raised.
  - WAIT_DONE, tx_busy_i=0: go to IDLE.
  - The FSM never issues tx_start_o while tx_busy_i=1 or during WAIT_*.
- Latency and throughput
  - Push sampled at edge E into an empty FIFO with FSM in IDLE: level_o=1 after E; tx_start_o high in the cycle after E+1.
  - Consecutive bytes: one IDLE cycle between WAIT_DONE exit and the next start pulse.
- idle_o = empty_o && state==IDLE, registered.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum tx_fifo_state_t
  - default depth UART_TX_FIFO_DEPTH=16
  - status-bit positions for the TX-level/overflow fields consumed by the controller
- One sub-module: uart_fifo_ram, a DEPTHx8 register array with synchronous write and asynchronous read by pointer.
- Pointer, level and FSM logic stay in uart_tx_fifo.

Test Plan:
- Reset, then push 0x41 at cycle 0 with tx_busy_i model asserting busy one cycle after start for 10 cycles:
  - level_o=1 at cycle 1
  - tx_start_o=1 with tx_data_o=0x41 at cycle 2
  - idle_o=1 after busy falls plus one cycle
- Push 16 bytes 0x00..0x0F back-to-back with the transmitter model holding busy long:
  - full_o=1 after the 16th push, minus any byte already popped
  - bytes emitted in order 0x00..0x0F with no duplicates
- Fill to 16 while the FSM is in WAIT_DONE, then push 0xAA:
  - byte dropped, ovf_o=1, level_o stays 16
  - ovf_clr_i pulse clears ovf_o
- Full FIFO, push 0x55 in the same cycle the FSM pops:
  - push accepted, level_o=16
  - 0x55 emitted last
- Transmitter model never raises busy:
  - after the start pulse, FSM returns to IDLE after 4 cycles and launches the next byte
- Assert rst_ni low during WAIT_DONE with 5 bytes queued:
  - level_o=0, empty_o=1, tx_start_o=0 immediately
  - no further start pulses after release
